nibble_serial_adder_ctrl: RTL

- Sequencer that performs a WIDTH-bit addition by reusing one 4-bit ripple-carry adder slice over WIDTH/4 cycles, least significant nibble first.
- Sits between the PE operand registers and the accumulator in the systolic array.
- Trades latency for area: one 4-bit slice replaces a full-width adder.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/adder_pkg.sv | 18 +
 rtl/nibble_adder_slice.sv | 21 ++
 rtl/nibble_serial_adder_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states
// and the nibble-counter width helper.
package adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width is clog2(n), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit ripple-carry adder built from four full adders.
module nibble_adder_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles,
// least significant nibble first, with valid/ready on both sides.
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / NIB_W;
  localparam int unsigned CW  = cnt_width(NIB);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d, carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NIB_W-1:0] nib_a, nib_b, nib_s;
  logic             nib_co;
  logic             last;

  assign last = (cnt_q == CW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Nibble k of each operand feeds the single slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned k = 0; k < NIB; k++) begin
      if (cnt_q == CW'(k)) begin
        nib_a = a_q[k*NIB_W +: NIB_W];
        nib_b = b_q[k*NIB_W +: NIB_W];
      end
    end
  end

  nibble_adder_slice u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_s),
    .cout (nib_co)
  );

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          cout_d  = 1'b0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < NIB; k++) begin
          if (cnt_q == CW'(k)) sum_d[k*NIB_W +: NIB_W] = nib_s;
        end
        carry_d = nib_co;
        if (last) begin
          cout_d = nib_co;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
